dmem_arbiter: RTL

- Shared data-memory arbiter sitting directly downstream of the processor cores.
- Each core's data-memory request (DMADDR, DOUT, MEMREAD, MEMWR) enters one requester slot.
- The arbiter serialises requests onto a single-port synchronous data memory (1-cycle read latency), returns read data on DIN and signals completion per core with an ACK pulse.
- Core control units hold their memory state until ACK.

---
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the processor cores / data memory and dmem_arbiter.
// master: the cores plus the memory model; slave: the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned NCORES = 4,
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16
);
    logic [NCORES-1:0]    REQRD;
    logic [NCORES-1:0]    REQWR;
    logic [AW*NCORES-1:0] ADDR;
    logic [DW*NCORES-1:0] WDATA;
    logic [DW-1:0]        DIN;
    logic [NCORES-1:0]    ACK;
    logic                 BUSY;
    logic [AW-1:0]        MADDR;
    logic [DW-1:0]        MWDATA;
    logic                 MRE;
    logic                 MWE;
    logic [DW-1:0]        MRDATA;

    modport master (
        output REQRD, REQWR, ADDR, WDATA, MRDATA,
        input  DIN, ACK, BUSY, MADDR, MWDATA, MRE, MWE
    );

    modport slave (
        input  REQRD, REQWR, ADDR, WDATA, MRDATA,
        output DIN, ACK, BUSY, MADDR, MWDATA, MRE, MWE
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shared data-memory arbiter: serialises per-core read/write requests onto a
// single-port synchronous memory with 1-cycle read latency, ACKs each core.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, pointer held at 0); default is round-robin.
module dmem_arbiter #(
    parameter int unsigned NCORES = 4,
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16
) (
    input  logic          clk,
    input  logic          rstn,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     idx;
    logic              mask;
    logic              op_wr;
    logic [NCORES-1:0] req;
    logic              found;
    logic [IW-1:0]     win;
    int unsigned       slot;

    assign req = bus.REQRD | bus.REQWR;

    // Winner search: first requesting slot from ptr upward with wrap-around,
    // skipping the slot just served while the mask flag is set.
    always_comb begin
        found = 1'b0;
        win   = '0;
        slot  = 0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            slot = (32'(ptr) + i) % NCORES;
            if (!found && req[IW'(slot)] && !(mask && (IW'(slot) == idx))) begin
                found = 1'b1;
                win   = IW'(slot);
            end
        end
    end

    // Arbiter FSM with registered memory strobes, ACK, DIN and BUSY.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            mask       <= 1'b0;
            op_wr      <= 1'b0;
            bus.DIN    <= '0;
            bus.ACK    <= '0;
            bus.BUSY   <= 1'b0;
            bus.MADDR  <= '0;
            bus.MWDATA <= '0;
            bus.MRE    <= 1'b0;
            bus.MWE    <= 1'b0;
        end else begin
            bus.ACK <= '0;
            case (state)
                IDLE: begin
                    mask <= 1'b0;
                    if (found) begin
                        // Address/data are latched straight into the memory
                        // port registers so they appear during ACCESS.
                        idx        <= win;
                        op_wr      <= bus.REQWR[win];
                        bus.MADDR  <= bus.ADDR[AW*win +: AW];
                        bus.MWDATA <= bus.WDATA[DW*win +: DW];
                        bus.MRE    <= ~bus.REQWR[win];
                        bus.MWE    <= bus.REQWR[win];
                        bus.BUSY   <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.MADDR  <= '0;
                    bus.MWDATA <= '0;
                    bus.MRE    <= 1'b0;
                    bus.MWE    <= 1'b0;
                    if (op_wr) begin
                        bus.ACK[idx] <= 1'b1;
                        state        <= DONE;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    bus.DIN      <= bus.MRDATA;
                    bus.ACK[idx] <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    ptr <= '0;
`else
                    if (idx == IW'(NCORES - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= idx + 1'b1;
                    end
`endif
                    mask     <= 1'b1;
                    bus.BUSY <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
